seg_scan_mux: RTL and testbench
===============================

# seg_scan_mux

Parametrised time-multiplexed seven-segment scan driver. It replaces the fixed 4-digit scanner that stepped one digit per fast-clock edge. This block has a configurable digit count, an internal refresh divider, per-digit blanking, per-digit blink for adjust mode, and PWM brightness. It sits between the stopwatch digit/segment encoders and the board's segment/anode pins.

## Interface
Parameters:
- NUM_DIGITS, 4: digits scanned, legal 1..16; IDX_W = max(1, clog2(NUM_DIGITS)).
- SEG_W, 8: segment bits per digit (7 segments + dp).
- SEG_BLANK, {SEG_W{1'b1}}: seg_out value whenever no digit is lit (active-low segments).
- REFRESH_DIV, 50000: clk cycles per digit slot; must be a multiple of 2^DIM_W and ≥ 2^DIM_W.
- DIM_W, 3: brightness width.
- BLINK_DIV, 25000000: clk cycles per blink half-period, ≥ 1.

Ports:
- clk, in, 1: single clock. All logic on rising edge.
- rst, in, 1: asynchronous, active-high reset.
- seg_in, in, NUM_DIGITS*SEG_W: digit d pattern at [d*SEG_W +: SEG_W]. Digit 0 is leftmost.
- digit_en, in, NUM_DIGITS: 1 = digit may light; 0 = digit blanked permanently.
- blink_en, in, 1: adjust mode; enables blinking.
- blink_mask, in, NUM_DIGITS: digits that blink while blink_en=1.
- brightness, in, DIM_W: 0 = dimmest, all-ones = brightest.
- seg_out, out, SEG_W: registered segment drive.
- an, out, NUM_DIGITS: registered anode drive, active-low, at most one bit low.
- digit_idx, out, IDX_W: registered index of the current slot.
- frame_tick, out, 1: one-cycle pulse at the start of each slot 0.

## Operation
- State: `cnt` (0..REFRESH_DIV-1), `idx` (0..NUM_DIGITS-1), `bcnt` (0..BLINK_DIV-1), `bphase` (1 bit).
- `cnt` increments every cycle. At REFRESH_DIV-1 it wraps to 0 and `idx` advances.
- `idx` wraps from NUM_DIGITS-1 to 0. Codes ≥ NUM_DIGITS are never reached, including for non-power-of-2 counts.
- Sub-slot: SUB = REFRESH_DIV >> DIM_W and sub = cnt / SUB.
- lit = (cnt != 0) && (sub <= brightness) && digit_en[idx] && !(blink_en && blink_mask[idx] && bphase).
- The cnt==0 dead cycle blanks the anodes at every digit change to prevent ghosting.
- When lit: an = ~(1 << idx) and seg_out = seg_in slice idx. Otherwise: an = all ones and seg_out = SEG_BLANK.
- Blink behaviour:
  - While blink_en=0, bcnt=0 and bphase=0.
  - While blink_en=1, bcnt counts; at BLINK_DIV-1 it wraps and bphase toggles.
  - Each blink_en assertion therefore starts in the visible phase, and the first blank phase begins BLINK_DIV cycles later.
- digit_idx mirrors idx. frame_tick=1 when the registered outputs reflect idx=0 and cnt=0.
- Inputs are sampled every cycle with no latching. Changes to seg_in, digit_en, brightness or blink_mask take effect mid-slot.

## Timing
- Reset values (async, immediate): cnt=0, idx=0, bcnt=0, bphase=0, an=all ones, seg_out=SEG_BLANK, digit_idx=0, frame_tick=0.
- Outputs are registered functions of pre-edge state and inputs: one-cycle latency from counter state and from any input change.
- First cycle after reset release: outputs reflect cnt=0 and idx=0. frame_tick=1; all anodes off (dead cycle).
- Slot length is exactly REFRESH_DIV cycles. Frame length is NUM_DIGITS*REFRESH_DIV. frame_tick period equals the frame length.
- Lit cycles per slot: min((brightness+1)*SUB, REFRESH_DIV) - 1.
- Reset mid-slot aborts the scan. Restart always begins at digit 0 with blink visible.
- NUM_DIGITS=1: idx stays 0 and frame_tick pulses once per REFRESH_DIV cycles.

## Test plan
Bench parameters: NUM_DIGITS=3, REFRESH_DIV=8, DIM_W=2, BLINK_DIV=20, brightness=3, all digit_en=1, seg_in={8'h03,8'h9F,8'h25} (digit2, digit1, digit0).
- **Reset/scan:** release rst → frame_tick at cycle 1, then every 24 cycles. an sequence per slot: 111 (1 cycle), then 110 with seg_out=8'h25 (7 cycles); then 101/8'h9F, 011/8'h03; then back to 110. No an=111→100 glitch.
- **Brightness:** brightness=0 → an low only at slot cycle 1 (cnt=1). brightness=1 → an low at cnt 1..3. brightness=3 → cnt 1..7.
- **Blanking:** digit_en=3'b101 → slot 1 shows an=111 and seg_out=8'hFF for all 8 cycles. Slots 0 and 2 are unchanged.
- **Blink:** blink_en=1, blink_mask=3'b010 → digit 1 visible for 20 cycles, blanked for 20, visible again. Digits 0 and 2 are unaffected. Drop blink_en mid-blank-phase → digit 1 lit in its next lit cycle; re-assert → visible phase first.
- **Async reset mid-operation:** assert rst at idx=2, cnt=5 → an=111 and seg_out=8'hFF without waiting for a clock edge. After release, the scan restarts at digit 0 with frame_tick.

Source files
------------

// File: rtl/seg_scan_mux.sv
// Time-multiplexed seven-segment scan driver with per-digit blanking, blink and
// PWM brightness. Every output is a registered function of pre-edge state and inputs.
module seg_scan_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int SEG_W       = 8,
    parameter logic [SEG_W-1:0] SEG_BLANK = {SEG_W{1'b1}},
    parameter int REFRESH_DIV = 50000,
    parameter int DIM_W       = 3,
    parameter int BLINK_DIV   = 25000000,
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_DIGITS*SEG_W-1:0] seg_in,
    input  logic [NUM_DIGITS-1:0]       digit_en,
    input  logic                        blink_en,
    input  logic [NUM_DIGITS-1:0]       blink_mask,
    input  logic [DIM_W-1:0]            brightness,
    output logic [SEG_W-1:0]            seg_out,
    output logic [NUM_DIGITS-1:0]       an,
    output logic [IDX_W-1:0]            digit_idx,
    output logic                        frame_tick
);

    localparam int CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BCNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int SUB    = REFRESH_DIV >> DIM_W;

    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BCNT_W-1:0] BCNT_MAX = BCNT_W'(BLINK_DIV - 1);
    localparam logic [CNT_W-1:0]  SUB_LEN  = CNT_W'(SUB);

    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic [BCNT_W-1:0]     bcnt;
    logic                  bphase;

    logic [CNT_W-1:0]      sub;
    logic                  lit;
    logic [SEG_W-1:0]      seg_next;
    logic [NUM_DIGITS-1:0] an_next;
    logic                  tick_next;

    // Slot counter and digit index; idx wraps explicitly so unused codes are never entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
            idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Blink timer is held cleared outside adjust mode so each entry starts visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt   <= '0;
            bphase <= 1'b0;
        end else if (!blink_en) begin
            bcnt   <= '0;
            bphase <= 1'b0;
        end else if (bcnt == BCNT_MAX) begin
            bcnt   <= '0;
            bphase <= ~bphase;
        end else begin
            bcnt <= bcnt + 1'b1;
        end
    end

    assign sub = cnt / SUB_LEN;

    // cnt==0 is a dead cycle so the anodes are dark across every digit change.
    always_comb begin
        lit       = 1'b0;
        seg_next  = SEG_BLANK;
        an_next   = '1;
        tick_next = (cnt == '0) && (idx == '0);
        lit = (cnt != '0)
            && (sub <= CNT_W'(brightness))
            && digit_en[idx]
            && !(blink_en && blink_mask[idx] && bphase);
        if (lit) begin
            seg_next = seg_in[int'(idx)*SEG_W +: SEG_W];
            an_next  = ~(NUM_DIGITS'(1) << idx);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_out    <= SEG_BLANK;
            an         <= '1;
            digit_idx  <= '0;
            frame_tick <= 1'b0;
        end else begin
            seg_out    <= seg_next;
            an         <= an_next;
            digit_idx  <= idx;
            frame_tick <= tick_next;
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Randomized scoreboard bench for seg_scan_mux: a time-based reference model
// predicts each cycle's outputs and a separate monitor compares them.
module tb_seg_scan_mux;

    localparam int N  = 3;
    localparam int SW = 8;
    localparam int R  = 8;
    localparam int DW = 2;
    localparam int BD = 20;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [N*SW-1:0]   seg_in;
    logic [N-1:0]      digit_en;
    logic              blink_en;
    logic [N-1:0]      blink_mask;
    logic [DW-1:0]     brightness;
    logic [SW-1:0]     seg_out;
    logic [N-1:0]      an;
    logic [1:0]        digit_idx;
    logic              frame_tick;

    typedef struct packed {
        logic [SW-1:0] seg;
        logic [N-1:0]  an;
        logic [1:0]    idx;
        logic          ft;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   tick = 0;
    int   blink_run = 0;

    seg_scan_mux #(
        .NUM_DIGITS (N),
        .SEG_W      (SW),
        .SEG_BLANK  (8'hFF),
        .REFRESH_DIV(R),
        .DIM_W      (DW),
        .BLINK_DIV  (BD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_in    (seg_in),
        .digit_en  (digit_en),
        .blink_en  (blink_en),
        .blink_mask(blink_mask),
        .brightness(brightness),
        .seg_out   (seg_out),
        .an        (an),
        .digit_idx (digit_idx),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    // Reference model: the scan position follows purely from cycles elapsed since reset
    // release, and the blink phase from how long blink_en has been held high.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                tick      = 0;
                blink_run = 0;
                exp_q.delete();
            end else begin
                automatic int   c     = tick % R;
                automatic int   d     = (tick / R) % N;
                automatic int   sub   = c / (R >> DW);
                automatic int   bph   = (blink_run / BD) % 2;
                automatic logic [N-1:0] one = 1;
                automatic logic lit;
                automatic exp_t e;
                lit = (c != 0) && (sub <= int'(brightness)) && digit_en[d]
                      && !(blink_en && blink_mask[d] && bph == 1);
                e.an  = lit ? ~(one << d) : '1;
                e.seg = lit ? seg_in[d*SW +: SW] : 8'hFF;
                e.idx = 2'(d);
                e.ft  = ((tick % (N * R)) == 0);
                exp_q.push_back(e);
                tick++;
                blink_run = blink_en ? blink_run + 1 : 0;
            end
        end
    end

    // Monitor: outputs are presented every cycle, so one expectation is consumed per edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                if (exp_q.size() == 0) begin
                    check_output("scoreboard_empty", 32'd0, 32'd1);
                end else begin
                    automatic exp_t e = exp_q.pop_front();
                    check_output("an", 32'(an), 32'(e.an));
                    check_output("seg_out", 32'(seg_out), 32'(e.seg));
                    check_output("digit_idx", 32'(digit_idx), 32'(e.idx));
                    check_output("frame_tick", 32'(frame_tick), 32'(e.ft));
                end
            end
        end
    end

    task automatic apply_stimulus(input logic [DW-1:0] br, input logic [N-1:0] den,
                                  input logic ben, input logic [N-1:0] bmask, input int cycles);
        @(negedge clk);
        brightness = br;
        digit_en   = den;
        blink_en   = ben;
        blink_mask = bmask;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_an"}, 32'(an), 32'h7);
        check_output({tag, "_seg"}, 32'(seg_out), 32'hFF);
        check_output({tag, "_idx"}, 32'(digit_idx), 32'h0);
        check_output({tag, "_ft"}, 32'(frame_tick), 32'h0);
    endtask

    initial begin
        seg_in     = {8'h03, 8'h9F, 8'h25};
        digit_en   = 3'b111;
        blink_en   = 1'b0;
        blink_mask = 3'b000;
        brightness = 2'd3;
        #1 rst = 1'b1;
        #1 check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;

        apply_stimulus(2'd3, 3'b111, 1'b0, 3'b000, 60);
        apply_stimulus(2'd0, 3'b111, 1'b0, 3'b000, 30);
        apply_stimulus(2'd1, 3'b111, 1'b0, 3'b000, 30);
        apply_stimulus(2'd3, 3'b101, 1'b0, 3'b000, 30);
        apply_stimulus(2'd3, 3'b111, 1'b1, 3'b010, 30);
        apply_stimulus(2'd3, 3'b111, 1'b0, 3'b010, 10);
        apply_stimulus(2'd3, 3'b111, 1'b1, 3'b010, 50);

        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            case ($urandom_range(0, 15))
                0: brightness = 2'($urandom_range(0, 3));
                1: digit_en   = 3'($urandom_range(0, 7));
                2: blink_en   = ~blink_en;
                3: blink_mask = 3'($urandom_range(0, 7));
                4: seg_in     = 24'($urandom);
                default: ;
            endcase
        end

        apply_stimulus(2'd3, 3'b111, 1'b0, 3'b000, 2);
        begin
            automatic bit found = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if ((tick % R) == 5 && ((tick / R) % N) == 2) begin
                    found = 1'b1;
                    break;
                end
            end
            if (!found) check_output("wait_idx2_cnt5", 32'd0, 32'd1);
        end
        #1 rst = 1'b1;
        #1 check_reset_outputs("midreset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        apply_stimulus(2'd3, 3'b111, 1'b1, 3'b111, 60);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
